reg_file_wb: RTL

Architectural register file and pending-write scoreboard. It sits at the receiving end of the write-back stage and is the other end of the write-back interface. It accepts the selected write-back data and destination register from write-back, and serves two combinational read ports to decode with same-cycle write-back bypass. Per-register pending-write counters let decode detect read-after-write hazards and raise a stall.

---
 rtl/reg_file_wb.sv | 98 +++++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// reg_file_wb
//   Architectural register file with a per-register pending-write scoreboard.
//   Write-back data lands in the array on the rising edge and is bypassed to
//   both read ports in the same cycle. Decode uses the busy/stall outputs to
//   hold instructions whose sources still have outstanding writes.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   wb_en/addr/data     : write-back valid, destination register, write data
//   issue_en/issue_rd   : decode issues an instruction that will write issue_rd
//   rs_addr/rt_addr     : read port indices
//   rs_data/rt_data     : read port data (with same-cycle write-back bypass)
//   rs_busy/rt_busy     : read register still has an outstanding write
//   stall               : rs_busy | rt_busy
//   sb_err              : sticky counter overflow/underflow flag
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic              sb_err
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];

  logic rs_hit;
  logic rt_hit;

  // Register array, pending-write counters and the sticky error flag.
  // Entry 0 is only ever written by reset, so it stays zero and its counter
  // never moves. A simultaneous issue and write-back to the same register
  // cancel out, leaving the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_en && wb_addr != '0)
        regs[wb_addr] <= wb_data;
      for (int r = 1; r < NREG; r++) begin
        if ((issue_en && issue_rd == ADDR_W'(r)) && !(wb_en && wb_addr == ADDR_W'(r))) begin
          // Saturate on overflow and flag it
          if (cnt[r] == CNT_MAX)
            sb_err <= 1'b1;
          else
            cnt[r] <= cnt[r] + 1'b1;
        end else if ((wb_en && wb_addr == ADDR_W'(r)) && !(issue_en && issue_rd == ADDR_W'(r))) begin
          // Write-back with nothing outstanding: data is still written above
          if (cnt[r] == '0)
            sb_err <= 1'b1;
          else
            cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Read ports with bypass. A write-back that retires the last outstanding
  // write clears busy in the same cycle because the bypassed data is valid.
  // Everything reads as zero while reset is held, even if wb_en is driven.
  always_comb begin
    rs_hit  = wb_en && (wb_addr == rs_addr) && (rs_addr != '0);
    rt_hit  = wb_en && (wb_addr == rt_addr) && (rt_addr != '0);
    rs_data = '0;
    rt_data = '0;
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (rst_n) begin
      rs_data = rs_hit ? wb_data : regs[rs_addr];
      rt_data = rt_hit ? wb_data : regs[rt_addr];
      rs_busy = (cnt[rs_addr] - CNT_W'(rs_hit)) != '0;
      rt_busy = (cnt[rt_addr] - CNT_W'(rt_hit)) != '0;
    end
    stall = rs_busy | rt_busy;
  end

endmodule
